// File: rtl/save_data.sv
// save_data: writes a level's brick records into consecutive RAM words
// starting at the level's base slot. Closes the list with a terminator word.
// One record is accepted per two cycles: handshake, then a one-cycle write.
module save_data #(
    parameter int          MAX_BRICKS = 32,
    parameter logic [19:0] SENTINEL   = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [9:0]  selection,
    input  logic        rec_valid,
    input  logic [9:0]  rec_x,
    input  logic [9:0]  rec_y,
    input  logic        rec_last,
    output logic        rec_ready,
    output logic        wren,
    output logic [9:0]  address,
    output logic [19:0] data,
    output logic [9:0]  count,
    output logic        done,
    output logic        overflow
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        WRITE  = 3'd2,
        TERM   = 3'd3,
        DONE   = 3'd4
    } state_t;

    // The last slot of a level is reserved for the terminator.
    localparam logic [9:0] FULL_COUNT = 10'(MAX_BRICKS - 1);

    state_t      state_r;
    logic [9:0]  base_r;
    logic        last_r;
    logic [9:0]  count_next_s;
    logic        full_s;

    // Base slot of a level; the product is deliberately truncated to the RAM width.
    function automatic logic [9:0] level_base(input logic [9:0] sel);
        logic [31:0] product;
        product = 32'(sel) * 32'(MAX_BRICKS);
        return product[9:0];
    endfunction

    // Packs a record into a RAM word.
    // A record equal to the terminator has y nudged down, so the loader never stops early.
    function automatic logic [19:0] record_word(input logic [9:0] x, input logic [9:0] y);
        logic [19:0] word;
        if ((x == 10'h3FF) && (y == 10'h3FF)) begin
            word = {x, 10'h3FE};
        end else begin
            word = {x, y};
        end
        return word;
    endfunction

    // Record count after the current write, and whether that fills the level.
    always_comb begin
        count_next_s = count + 10'd1;
        if (count_next_s == FULL_COUNT) begin
            full_s = 1'b1;
        end else begin
            full_s = 1'b0;
        end
    end

    // Session FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= IDLE;
            base_r    <= 10'd0;
            last_r    <= 1'b0;
            rec_ready <= 1'b0;
            wren      <= 1'b0;
            address   <= 10'd0;
            data      <= 20'd0;
            count     <= 10'd0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    wren <= 1'b0;
                    if (start) begin
                        base_r    <= level_base(selection);
                        count     <= 10'd0;
                        done      <= 1'b0;
                        overflow  <= 1'b0;
                        last_r    <= 1'b0;
                        rec_ready <= 1'b1;
                        state_r   <= ACCEPT;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ACCEPT: begin
                    if (rec_valid) begin
                        data      <= record_word(rec_x, rec_y);
                        address   <= base_r + count;
                        last_r    <= rec_last;
                        rec_ready <= 1'b0;
                        wren      <= 1'b1;
                        state_r   <= WRITE;
                    end else begin
                        rec_ready <= 1'b1;
                        wren      <= 1'b0;
                    end
                end
                WRITE: begin
                    count <= count_next_s;
                    if (last_r || full_s) begin
                        // The terminator goes in the slot right after the last record.
                        address  <= base_r + count_next_s;
                        data     <= SENTINEL;
                        overflow <= full_s && !last_r;
                        wren     <= 1'b1;
                        state_r  <= TERM;
                    end else begin
                        wren      <= 1'b0;
                        rec_ready <= 1'b1;
                        state_r   <= ACCEPT;
                    end
                end
                TERM: begin
                    wren    <= 1'b0;
                    done    <= 1'b1;
                    state_r <= DONE;
                end
                default: begin
                    rec_ready <= 1'b0;
                    wren      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_save_data.sv
// tb_save_data: directed and randomized sessions against a list-level model of the writer.
module tb_save_data;

    localparam int MAXB = 32;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  selection = 10'd0;
    logic        rec_valid = 1'b0;
    logic [9:0]  rec_x = 10'd0;
    logic [9:0]  rec_y = 10'd0;
    logic        rec_last = 1'b0;
    logic        rec_ready;
    logic        wren;
    logic [9:0]  address;
    logic [19:0] data;
    logic [9:0]  count;
    logic        done;
    logic        overflow;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [9:0]  xs [64];
    logic [9:0]  ys [64];
    int          hs_cyc [$];
    int          wr_cyc [$];
    logic [9:0]  wr_addr [$];
    logic [19:0] wr_data [$];

    save_data #(.MAX_BRICKS(MAXB), .SENTINEL(20'hFFFFF)) dut (
        .clk(clk), .resetn(resetn), .start(start), .selection(selection),
        .rec_valid(rec_valid), .rec_x(rec_x), .rec_y(rec_y), .rec_last(rec_last),
        .rec_ready(rec_ready), .wren(wren), .address(address), .data(data),
        .count(count), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Monitor: log handshakes and memory writes, sampled mid-cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (resetn) begin
            if (rec_valid && rec_ready) hs_cyc.push_back(cyc);
            if (wren) begin
                wr_cyc.push_back(cyc);
                wr_addr.push_back(address);
                wr_data.push_back(data);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] exp_word(input logic [9:0] x, input logic [9:0] y);
        if (x == 10'h3FF && y == 10'h3FF) return 20'hFFFFE;
        return {x, y};
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            xs[i] = 10'($urandom_range(0, 1023));
            ys[i] = 10'($urandom_range(0, 1023));
        end
    endtask

    task automatic clear_log();
        hs_cyc.delete(); wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    endtask

    task automatic run_session(input logic [9:0] sel, input int n, input int last_at, input bit bp);
        int idx;
        int guard;
        bit hs;
        clear_log();
        @(posedge clk); #1; start = 1'b1; selection = sel;
        @(posedge clk); #1; start = 1'b0;
        idx = 0; guard = 0;
        while (idx < n && !done && guard < 3000) begin
            rec_x = xs[idx]; rec_y = ys[idx]; rec_last = (idx == last_at);
            rec_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk); hs = rec_valid && rec_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            guard++;
        end
        guard = 0;
        while (!done && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        check("done_seen", 32'(done), 32'd1);
        // Keep offering data after the session ends; nothing more may be taken.
        repeat (4) @(posedge clk);
        #1; rec_valid = 1'b0; rec_last = 1'b0;
    endtask

    // Model: the level's list is the records up to rec_last or until the level is full,
    // followed by one terminator; each data write trails its handshake by one cycle.
    task automatic check_session(input logic [9:0] sel, input int n, input int last_at, input bit spaced);
        int acc;
        int base;
        int nw;
        bit ovf;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            acc++;
            if (i == last_at || acc == MAXB - 1) break;
        end
        ovf = (acc == MAXB - 1) && (last_at != acc - 1);
        base = (int'(sel) * MAXB) % 1024;
        check("handshakes", 32'(hs_cyc.size()), 32'(acc));
        check("writes", 32'(wr_cyc.size()), 32'(acc + 1));
        nw = (wr_cyc.size() < acc + 1) ? wr_cyc.size() : acc + 1;
        for (int i = 0; i < nw; i++) begin
            check("addr", 32'(wr_addr[i]), 32'((base + i) % 1024));
            if (i < acc) begin
                check("data", 32'(wr_data[i]), 32'(exp_word(xs[i], ys[i])));
                if (i < hs_cyc.size()) check("latency", 32'(wr_cyc[i]), 32'(hs_cyc[i] + 1));
                if (spaced && i > 0) check("spacing", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd2);
            end else begin
                check("sentinel", 32'(wr_data[i]), 32'hFFFFF);
                if (i > 0) check("term_follows", 32'(wr_cyc[i]), 32'(wr_cyc[i-1] + 1));
            end
        end
        check("count", 32'(count), 32'(acc));
        check("done", 32'(done), 32'd1);
        check("overflow", 32'(overflow), 32'(ovf));
        check("ready_after", 32'(rec_ready), 32'd0);
        check("wren_after", 32'(wren), 32'd0);
    endtask

    initial begin
        int guard;
        int n;
        int last_at;
        logic [9:0] sel;

        // Power-on reset values
        #3;
        check("rst_ready", 32'(rec_ready), 32'd0);
        check("rst_wren", 32'(wren), 32'd0);
        check("rst_addr", 32'(address), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        #14; resetn = 1'b1;

        // Basic three-record session at level 2
        xs[0] = 10'd10; ys[0] = 10'd20;
        xs[1] = 10'd30; ys[1] = 10'd40;
        xs[2] = 10'd50; ys[2] = 10'd60;
        run_session(10'd2, 3, 2, 1'b0);
        check_session(10'd2, 3, 2, 1'b1);

        // Back-pressure with random valid
        fill_random(5);
        sel = 10'($urandom_range(0, 1023));
        run_session(sel, 5, 4, 1'b1);
        check_session(sel, 5, 4, 1'b0);

        // Overflow: 40 offered, no rec_last
        fill_random(40);
        run_session(10'd0, 40, 1000, 1'b0);
        check_session(10'd0, 40, 1000, 1'b1);

        // Boundary: the 31st record carries rec_last
        fill_random(31);
        run_session(10'd0, 31, 30, 1'b0);
        check_session(10'd0, 31, 30, 1'b1);

        // Collision with the terminator value
        fill_random(3);
        xs[1] = 10'h3FF; ys[1] = 10'h3FF;
        run_session(10'd7, 3, 2, 1'b0);
        check_session(10'd7, 3, 2, 1'b1);
        if (wr_data.size() > 1) check("collision", 32'(wr_data[1]), 32'hFFFFE);

        // Random sessions
        for (int s = 0; s < 4; s++) begin
            n = $urandom_range(1, 40);
            last_at = (n < MAXB - 1) ? n - 1 : $urandom_range(0, 40);
            sel = 10'($urandom_range(0, 1023));
            fill_random(n);
            run_session(sel, n, last_at, 1'($urandom_range(0, 1)));
            check_session(sel, n, last_at, 1'b0);
        end

        // Asynchronous reset while a write is in progress
        @(posedge clk); #1; start = 1'b1; selection = 10'd5;
        @(posedge clk); #1; start = 1'b0; rec_valid = 1'b1; rec_x = 10'd1; rec_y = 10'd2; rec_last = 1'b0;
        guard = 0;
        while (!wren && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        check("wren_before_reset", 32'(wren), 32'd1);
        #2; resetn = 1'b0; rec_valid = 1'b0;
        #1;
        check("arst_wren", 32'(wren), 32'd0);
        check("arst_ready", 32'(rec_ready), 32'd0);
        check("arst_addr", 32'(address), 32'd0);
        check("arst_data", 32'(data), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        @(negedge clk); #2; resetn = 1'b1;
        fill_random(3);
        run_session(10'd1, 3, 2, 1'b0);
        check_session(10'd1, 3, 2, 1'b1);
        if (wr_addr.size() > 0) check("after_reset_base", 32'(wr_addr[0]), 32'd32);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
